// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced level to press/release/short/long/repeat pulses; AUTO_REPEAT_EN enables auto-repeat
module button_event_decoder #(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;

    // Terminal counts; the counter resets to 0 when it reaches these, so it never wraps.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 || CNT_W < 1) begin : g_param_check
        $error("button_event_decoder: illegal LONG_CYCLES/REPEAT_CYCLES/CNT_W");
    end

    state_t           state;
    logic             prev_level;
    logic [CNT_W-1:0] hold_cnt;
    logic             rise;
    logic             fall;

    assign rise = button_level & ~prev_level;
    assign fall = ~button_level & prev_level;

    // Edge detect, hold timing and all registered pulse outputs; a fall always beats a threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            prev_level    <= 1'b0;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            prev_level    <= button_level;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state       <= PRESSED;
                        hold_cnt    <= '0;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state         <= IDLE;
                        hold_cnt      <= '0;
                        release_pulse <= 1'b1;
                        short_pulse   <= 1'b1;
                        held          <= 1'b0;
                    end else if (hold_cnt == LONG_LAST) begin
                        state      <= LONG_HELD;
                        hold_cnt   <= '0;
                        long_pulse <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state         <= IDLE;
                        hold_cnt      <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (hold_cnt == REPEAT_LAST) begin
                        hold_cnt     <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    held     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
module tb_button_event_decoder;

    localparam int L = 8;
    localparam int R = 4;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;
    localparam int K_SHORT   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button_level = 1'b1;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    button_event_decoder #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic       short_f;
        logic [7:0] count;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_count = 8'd0;

    task automatic push_ev(input int kind, input logic sh, input logic [7:0] cnt, input int at);
        ev_t e;
        e.kind    = kind;
        e.short_f = sh;
        e.count   = cnt;
        e.at      = at;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_pulses"}, {27'd0, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse}, 32'd0);
        chk({name, "_held"}, {31'd0, held}, 32'd0);
        chk({name, "_count"}, {24'd0, press_count}, 32'd0);
    endtask

    // One press of n_high sampled-high edges followed by n_low idle edges.
    task automatic tap(input int n_high, input int n_low);
        int e_rise;
        int e_fall;
        e_rise    = cyc + 1;
        e_fall    = e_rise + n_high;
        exp_count = exp_count + 8'd1;
        push_ev(K_PRESS, 1'b0, exp_count, e_rise);
        if (n_high > L) begin
            push_ev(K_LONG, 1'b0, exp_count, e_rise + L);
`ifdef AUTO_REPEAT_EN
            for (int t = e_rise + L + R; t < e_fall; t += R)
                push_ev(K_REPEAT, 1'b0, exp_count, t);
`endif
        end
        push_ev(K_RELEASE, (n_high <= L), exp_count, e_fall);
        button_level = 1'b1;
        for (int i = 0; i < n_high; i++) begin
            tick();
            chk("held_high", {31'd0, held}, 32'd1);
        end
        button_level = 1'b0;
        tick();
        chk("held_low", {31'd0, held}, 32'd0);
        for (int i = 0; i < n_low; i++) tick();
    endtask

    // Monitor: every pulse the DUT presents is matched against the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        int  kind;
        int  n;
        if (cyc > 0 && (press_pulse || release_pulse || long_pulse || repeat_pulse || short_pulse)) begin
            checks++;
            n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
            kind = press_pulse ? K_PRESS : release_pulse ? K_RELEASE :
                   long_pulse ? K_LONG : repeat_pulse ? K_REPEAT : K_SHORT;
            if (n > 1) begin
                errors++;
                $display("FAIL event_onehot: got p%0b r%0b l%0b rp%0b required at most one (cycle %0d)",
                         press_pulse, release_pulse, long_pulse, repeat_pulse, cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected: got kind %0d short %0b at cycle %0d, required no event",
                         kind, short_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind || short_pulse !== e.short_f || press_count !== e.count || cyc != e.at) begin
                    errors++;
                    $display("FAIL event_match: got kind %0d short %0b count %0d cycle %0d, required kind %0d short %0b count %0d cycle %0d",
                             kind, short_pulse, press_count, cyc, e.kind, e.short_f, e.count, e.at);
                end
            end
        end
    end

    initial begin
        // 1: reset held with level high, then a fresh press after deassert
        reset        = 1'b1;
        button_level = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("reset_hold");
        end
        reset = 1'b0;
        tap(3, 2);
        chk("count_after_first", {24'd0, press_count}, 32'd1);

        // 2: short tap of three cycles
        tap(3, 2);
        chk("count_after_short", {24'd0, press_count}, 32'd2);

        // 3: long hold of 20 cycles
        tap(20, 2);
        chk("count_after_long", {24'd0, press_count}, 32'd3);

        // 4: fall on the long-threshold edge
        tap(L, 2);
        chk("count_after_tie", {24'd0, press_count}, 32'd4);

        // 6: reset while in LONG_HELD
        begin
            int e_rise;
            e_rise    = cyc + 1;
            exp_count = exp_count + 8'd1;
            push_ev(K_PRESS, 1'b0, exp_count, e_rise);
            push_ev(K_LONG, 1'b0, exp_count, e_rise + L);
            button_level = 1'b1;
            for (int i = 0; i < L + 2; i++) tick();
            chk("long_held_before_reset", {31'd0, held}, 32'd1);
            reset = 1'b1;
            tick();
            chk_quiet("reset_mid_hold");
            exp_count    = 8'd0;
            button_level = 1'b0;
            tick();
            reset = 1'b0;
            for (int i = 0; i < 3; i++) tick();
            chk_quiet("after_mid_reset");
        end

        // 5: press_count wraps after 256 taps
        for (int i = 0; i < 256; i++) tap(1, 1);
        chk("count_wrap_0", {24'd0, press_count}, 32'd0);
        tap(1, 1);
        chk("count_wrap_1", {24'd0, press_count}, 32'd1);

        for (int i = 0; i < 5; i++) tick();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
